core_run_ctrl: RTL and testbench

Run-control sequencer for the single-cycle RV32I core. It owns the core's reset and clock-enable, boot-loads instruction memory through a valid/ready word stream, and starts, halts and resumes execution. It stops the core on ECALL/EBREAK, on an external halt command, or on a one-instruction step. It sits between the system/debug host and the `processor` + instruction memory pair.

---
 rtl/core_run_ctrl_if.sv | 10 +
 rtl/core_run_ctrl.sv | 131 +++++++++++++
 tb/tb_core_run_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_run_ctrl_if.sv
// Boot-load word stream between the host and core_run_ctrl (valid/ready, last-word marker).
interface core_run_ctrl_if;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic        ld_last;

  modport master (output ld_valid, ld_data, ld_last, input ld_ready);
  modport slave  (input ld_valid, ld_data, ld_last, output ld_ready);
endinterface

// File: rtl/core_run_ctrl.sv
// Run-control sequencer for the RV32I core: boot load, start/halt/resume, trap stop.
// Optional single-step support is enabled by defining CORE_CTRL_STEP_EN.
module core_run_ctrl #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_load_i,
  input  logic              cmd_run_i,
  input  logic              cmd_halt_i,
  input  logic              cmd_step_i,
  core_run_ctrl_if.slave    ld,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_waddr_o,
  output logic [31:0]       imem_wdata_o,
  input  logic [31:0]       instruction_i,
  output logic              core_reset_o,
  output logic              core_en_o,
  output logic [1:0]        state_o,
  output logic [1:0]        halt_cause_o,
  output logic [CNT_W-1:0]  retired_o
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StRun  = 2'd2,
    StHalt = 2'd3
  } state_e;

  localparam logic [31:0] InstrEcall  = 32'h0000_0073;
  localparam logic [31:0] InstrEbreak = 32'h0010_0073;

  state_e             state_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               core_reset_q;
  logic               skip_q;
  logic [1:0]         cause_q;
  logic [CNT_W-1:0]   retired_q;

  logic is_ecall, is_ebreak, hit;
  logic ld_ready, ld_fire, ld_done, step_fire;

  assign is_ecall  = (instruction_i == InstrEcall);
  assign is_ebreak = (instruction_i == InstrEbreak);
  // skip_q lets a resumed core execute the instruction that trapped it.
  assign hit       = (is_ecall | is_ebreak) & ~skip_q;

  assign ld_ready  = (state_q == StLoad) & ~cmd_halt_i;
  assign ld_fire   = ld.ld_valid & ld_ready;
  assign ld_done   = ld.ld_last | (addr_q == {ADDR_W{1'b1}});

`ifdef CORE_CTRL_STEP_EN
  assign step_fire = (state_q == StHalt) & cmd_step_i & ~cmd_load_i & ~cmd_run_i;
`else
  logic unused_cmd_step;
  assign unused_cmd_step = cmd_step_i;
  assign step_fire       = 1'b0;
`endif

  assign core_en_o    = ((state_q == StRun) & ~hit & ~cmd_halt_i) | step_fire;
  assign ld.ld_ready  = ld_ready;
  assign imem_we_o    = ld_fire;
  assign imem_waddr_o = addr_q;
  assign imem_wdata_o = ld.ld_data;
  assign core_reset_o = core_reset_q;
  assign state_o      = state_q;
  assign halt_cause_o = cause_q;
  assign retired_o    = retired_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      core_reset_q <= 1'b1;
      skip_q       <= 1'b0;
      cause_q      <= 2'd0;
      retired_q    <= '0;
    end else begin
      skip_q <= 1'b0;
      if (core_en_o) begin
        retired_q <= retired_q + CNT_W'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (cmd_load_i) begin
            state_q <= StLoad;
            addr_q  <= '0;
          end else if (cmd_run_i) begin
            state_q      <= StRun;
            core_reset_q <= 1'b0;
            retired_q    <= '0;
            cause_q      <= 2'd0;
          end
        end
        StLoad: begin
          if (cmd_halt_i) begin
            state_q <= StIdle;
          end else if (ld_fire) begin
            addr_q <= addr_q + ADDR_W'(1);
            if (ld_done) begin
              state_q <= StIdle;
            end
          end
        end
        StRun: begin
          if (cmd_halt_i) begin
            state_q <= StHalt;
            cause_q <= 2'd3;
          end else if (hit) begin
            state_q <= StHalt;
            cause_q <= is_ecall ? 2'd1 : 2'd2;
          end
        end
        StHalt: begin
          if (cmd_load_i) begin
            state_q      <= StLoad;
            addr_q       <= '0;
            core_reset_q <= 1'b1;
          end else if (cmd_run_i) begin
            state_q <= StRun;
            skip_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Scoreboard bench for core_run_ctrl: load, run/trap, resume, halt, step and address wrap.
module tb_core_run_ctrl;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned CNT_W  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int en_cnt   = 0;

  // DUT A (ADDR_W = 10)
  logic              cmd_load, cmd_run, cmd_halt, cmd_step;
  logic              imem_we, core_reset, core_en;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata, instruction;
  logic [1:0]        state, halt_cause;
  logic [CNT_W-1:0]  retired;
  core_run_ctrl_if   ld_a ();

  core_run_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut_a (
    .clk_i        (clk),
    .rst_i        (rst),
    .cmd_load_i   (cmd_load),
    .cmd_run_i    (cmd_run),
    .cmd_halt_i   (cmd_halt),
    .cmd_step_i   (cmd_step),
    .ld           (ld_a),
    .imem_we_o    (imem_we),
    .imem_waddr_o (imem_waddr),
    .imem_wdata_o (imem_wdata),
    .instruction_i(instruction),
    .core_reset_o (core_reset),
    .core_en_o    (core_en),
    .state_o      (state),
    .halt_cause_o (halt_cause),
    .retired_o    (retired)
  );

  // DUT B (ADDR_W = 2) for the address-wrap boundary
  logic             cmd_load_b, cmd_run_b, cmd_halt_b, cmd_step_b;
  logic             imem_we_b, core_reset_b, core_en_b;
  logic [1:0]       imem_waddr_b;
  logic [31:0]      imem_wdata_b, instruction_b;
  logic [1:0]       state_b, halt_cause_b;
  logic [CNT_W-1:0] retired_b;
  core_run_ctrl_if  ld_b ();

  core_run_ctrl #(.ADDR_W(2), .CNT_W(CNT_W)) dut_b (
    .clk_i        (clk),
    .rst_i        (rst),
    .cmd_load_i   (cmd_load_b),
    .cmd_run_i    (cmd_run_b),
    .cmd_halt_i   (cmd_halt_b),
    .cmd_step_i   (cmd_step_b),
    .ld           (ld_b),
    .imem_we_o    (imem_we_b),
    .imem_waddr_o (imem_waddr_b),
    .imem_wdata_o (imem_wdata_b),
    .instruction_i(instruction_b),
    .core_reset_o (core_reset_b),
    .core_en_o    (core_en_b),
    .state_o      (state_b),
    .halt_cause_o (halt_cause_b),
    .retired_o    (retired_b)
  );

  // Environment model: instruction memory plus a processor PC that advances on core_en.
  logic [31:0] mem [16];
  logic [3:0]  pc = 4'd0;
  initial for (int i = 0; i < 16; i++) mem[i] = 32'h0;
  always @(posedge clk) begin
    if (imem_we) mem[imem_waddr[3:0]] <= imem_wdata;
    if (core_reset) pc <= 4'd0;
    else if (core_en) pc <= pc + 4'd1;
  end
  assign instruction   = mem[pc];
  assign instruction_b = 32'h0;

  logic [63:0] wq_a [$];
  logic [63:0] wq_b [$];
  logic [31:0] eq [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got 0x%0h with nothing expected at %0t", name, act, $time);
  endtask

  // Monitor: pops expected memory writes and executed instructions.
  always @(negedge clk) begin
    if (imem_we) begin
      if (wq_a.size() == 0) unexpected("wr_a", {32'(imem_waddr), imem_wdata});
      else chk("wr_a", {32'(imem_waddr), imem_wdata}, wq_a.pop_front());
    end
    if (imem_we_b) begin
      if (wq_b.size() == 0) unexpected("wr_b", {32'(imem_waddr_b), imem_wdata_b});
      else chk("wr_b", {32'(imem_waddr_b), imem_wdata_b}, wq_b.pop_front());
    end
    if (core_en) begin
      en_cnt++;
      if (eq.size() == 0) unexpected("exec", 64'(instruction));
      else chk("exec", 64'(instruction), 64'(eq.pop_front()));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] prog [4];
  int          en_before;

  initial begin
    prog[0] = 32'h0050_0093;
    prog[1] = 32'h0010_8113;
    prog[2] = 32'h0000_0073;
    prog[3] = 32'h0000_0000;
    {cmd_load, cmd_run, cmd_halt, cmd_step} = 4'b0;
    {cmd_load_b, cmd_run_b, cmd_halt_b, cmd_step_b} = 4'b0;
    ld_a.ld_valid = 1'b0; ld_a.ld_data = 32'h0; ld_a.ld_last = 1'b0;
    ld_b.ld_valid = 1'b0; ld_b.ld_data = 32'h0; ld_b.ld_last = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_state", state, 0);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_core_en", core_en, 0);
    chk("rst_ld_ready", ld_a.ld_ready, 0);
    chk("rst_imem_we", imem_we, 0);
    chk("rst_waddr", imem_waddr, 0);
    chk("rst_retired", retired, 0);
    chk("rst_cause", halt_cause, 0);
    rst = 1'b0;

    // Boot load of four words
    cyc(); cmd_load = 1'b1;
    cyc(); cmd_load = 1'b0;
    chk("load_state", state, 1);
    for (int i = 0; i < 4; i++) begin
      ld_a.ld_valid = 1'b1;
      ld_a.ld_data  = prog[i];
      ld_a.ld_last  = (i == 3);
      wq_a.push_back({32'(i), prog[i]});
      #1;
      chk("load_core_reset", core_reset, 1);
      chk("load_ready", ld_a.ld_ready, 1);
      cyc();
    end
    ld_a.ld_valid = 1'b0; ld_a.ld_last = 1'b0;
    #1;
    chk("load_done_state", state, 0);
    chk("load_done_core_reset", core_reset, 1);

    // Run until ECALL
    cmd_run = 1'b1;
    eq.push_back(prog[0]);
    eq.push_back(prog[1]);
    cyc(); cmd_run = 1'b0;
    #1;
    chk("run_state", state, 2);
    chk("run_core_reset", core_reset, 0);
    chk("run_core_en", core_en, 1);
    cyc(); cyc(); cyc();
    #1;
    chk("ecall_state", state, 3);
    chk("ecall_cause", halt_cause, 1);
    chk("ecall_retired", retired, 2);
    chk("ecall_core_en", core_en, 0);

    // Resume past the ECALL, then halt+load together
    cmd_run = 1'b1;
    eq.push_back(32'h0000_0073);
    cyc(); cmd_run = 1'b0;
    #1;
    chk("resume_state", state, 2);
    chk("resume_skip_en", core_en, 1);
    cyc();
    #1;
    chk("resume_retired", retired, 3);
    chk("resume_continues", state, 2);
    cmd_halt = 1'b1; cmd_load = 1'b1;
    #1;
    chk("halt_zero_latency", core_en, 0);
    cyc(); cmd_halt = 1'b0; cmd_load = 1'b0;
    #1;
    chk("halt_state", state, 3);
    chk("halt_cause", halt_cause, 3);
    chk("halt_retired", retired, 3);
    chk("halt_core_reset", core_reset, 0);

    // Three step pulses in HALT
    en_before = en_cnt;
    for (int i = 0; i < 3; i++) begin
      cmd_step = 1'b1;
`ifdef CORE_CTRL_STEP_EN
      eq.push_back(32'h0);
`endif
      cyc(); cmd_step = 1'b0;
      cyc();
    end
    #1;
`ifdef CORE_CTRL_STEP_EN
    chk("step_en_cycles", 64'(en_cnt - en_before), 3);
    chk("step_retired", retired, 6);
`else
    chk("step_en_cycles", 64'(en_cnt - en_before), 0);
    chk("step_retired", retired, 3);
`endif
    chk("step_state", state, 3);
    chk("step_cause", halt_cause, 3);

    // HALT -> LOAD, then abort with cmd_halt while a word is offered
    cmd_load = 1'b1;
    cyc(); cmd_load = 1'b0;
    #1;
    chk("reload_state", state, 1);
    chk("reload_core_reset", core_reset, 1);
    ld_a.ld_valid = 1'b1; ld_a.ld_data = 32'hdead_beef; cmd_halt = 1'b1;
    #1;
    chk("abort_ready", ld_a.ld_ready, 0);
    chk("abort_we", imem_we, 0);
    cyc(); cmd_halt = 1'b0; ld_a.ld_valid = 1'b0;
    #1;
    chk("abort_state", state, 0);

    // Fresh start from IDLE clears retired
    cmd_run = 1'b1;
    eq.push_back(prog[0]);
    eq.push_back(prog[1]);
    cyc(); cmd_run = 1'b0;
    cyc(); cyc(); cyc();
    #1;
    chk("restart_state", state, 3);
    chk("restart_cause", halt_cause, 1);
    chk("restart_retired", retired, 2);

    // ADDR_W=2: fifth word must be refused after wrap back to IDLE
    cmd_load_b = 1'b1;
    cyc(); cmd_load_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ld_b.ld_valid = 1'b1;
      ld_b.ld_data  = 32'h1000 + 32'(i);
      ld_b.ld_last  = 1'b0;
      if (i < 4) wq_b.push_back({32'(i), 32'h1000 + 32'(i)});
      #1;
      if (i == 4) begin
        chk("wrap_ready", ld_b.ld_ready, 0);
        chk("wrap_we", imem_we_b, 0);
        chk("wrap_state", state_b, 0);
      end else begin
        chk("wrap_load_ready", ld_b.ld_ready, 1);
      end
      cyc();
    end
    ld_b.ld_valid = 1'b0;

    cyc(); cyc();
    chk("wq_a_drained", 64'(wq_a.size()), 0);
    chk("wq_b_drained", 64'(wq_b.size()), 0);
    chk("exec_drained", 64'(eq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
